gray_code_counter: RTL and testbench

- Synchronous up/down counter whose primary output is the Gray-coded count.
- Sits directly upstream of the Gray-to-binary converter and supplies its Gray input bits.
- Intended use: clock-domain-crossing pointers and glitch-free position codes.
- Internally counts in binary and registers a Gray-encoded copy, so the output never changes more than one bit per count step.

---
 rtl/gray_pkg.sv | 35 +++
 rtl/bin_to_gray.sv | 25 ++
 rtl/gray_code_counter.sv | 120 ++++++++++++
 tb/tb_gray_code_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared constants and Gray/binary conversion helpers for the
//                Gray-code counter and its neighbours.
//                  GRAY_MAX_WIDTH - widest counter supported
//                  bin2gray()     - binary -> reflected Gray
//                  gray2bin()     - reflected Gray -> binary
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position,
  // so walk from the MSB down carrying the running XOR.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
    input logic [GRAY_MAX_WIDTH-1:0] g
  );
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/bin_to_gray.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_gray
//  Description : Purely combinational WIDTH-bit binary to Gray converter.
//  Ports       : bin_in   [WIDTH-1:0] in   binary value
//                gray_out [WIDTH-1:0] out  reflected Gray code of bin_in
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin_in,
  output logic [WIDTH-1:0] gray_out
);

  // The MSB passes straight through; every other bit is the XOR of itself
  // with its upper neighbour.
  assign gray_out[WIDTH-1] = bin_in[WIDTH-1];

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
    assign gray_out[i] = bin_in[i] ^ bin_in[i+1];
  end

endmodule : bin_to_gray
`default_nettype wire

// File: rtl/gray_code_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_code_counter
//  Description : Up/down binary counter with a registered Gray-coded copy.
//                The Gray register is loaded from the converted next-binary
//                value, so gray_out and bin_out always move together and
//                gray_out changes by exactly one bit per counted step.
//  Options     : GRAY_CNT_SATURATE_EN - when defined, steps past the top or
//                bottom of the range are blocked (count holds, tc_out set)
//                instead of wrapping.
//  Ports       : clk_in       in   clock, rising edge
//                rst_in       in   asynchronous active-high reset
//                en_in        in   count enable
//                up_in        in   1 = increment, 0 = decrement
//                load_in      in   synchronous load (beats en_in)
//                load_val_in  in   binary load value [WIDTH-1:0]
//                gray_out     out  registered Gray count [WIDTH-1:0]
//                bin_out      out  registered binary count [WIDTH-1:0]
//                valid_out    out  1 the cycle after a load or enabled step
//                tc_out       out  1 the cycle the count wrapped (or a
//                                  saturating step was blocked)
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             up_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid_out,
  output logic             tc_out
);

  localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_zero = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             tc_q,    tc_d;

  // --------------------------------------------------------------------------
  // Next-state: load has priority over counting. A step off either end of
  // the range raises tc; whether the count wraps or holds there depends on
  // the saturation option.
  // --------------------------------------------------------------------------
  always_comb begin
    bin_d   = bin_q;
    valid_d = 1'b0;
    tc_d    = 1'b0;

    if (load_in) begin
      bin_d   = load_val_in;
      valid_d = 1'b1;
    end else if (en_in) begin
      valid_d = 1'b1;
      if (up_in) begin
        if (bin_q == c_max) begin
          tc_d = 1'b1;
`ifdef GRAY_CNT_SATURATE_EN
          bin_d = bin_q;
`else
          bin_d = c_zero;
`endif
        end else begin
          bin_d = bin_q + c_one;
        end
      end else begin
        if (bin_q == c_zero) begin
          tc_d = 1'b1;
`ifdef GRAY_CNT_SATURATE_EN
          bin_d = bin_q;
`else
          bin_d = c_max;
`endif
        end else begin
          bin_d = bin_q - c_one;
        end
      end
    end
  end

  // Gray is derived from the next binary value so both registers update on
  // the same edge with no extra pipeline stage.
  bin_to_gray #(
    .WIDTH (WIDTH)
  ) u_bin_to_gray (
    .bin_in   (bin_d),
    .gray_out (gray_d)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bin_q   <= c_zero;
      gray_q  <= c_zero;
      valid_q <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      tc_q    <= tc_d;
    end
  end

  assign gray_out  = gray_q;
  assign bin_out   = bin_q;
  assign valid_out = valid_q;
  assign tc_out    = tc_q;

endmodule : gray_code_counter
`default_nettype wire

// File: tb/tb_gray_code_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_code_counter
//  Description : Scoreboard bench for gray_code_counter (WIDTH=3). A driver
//                issues directed and random cycles, advancing an integer
//                reference count and pushing the expected outputs; a monitor
//                pops and compares once the corresponding edge has passed.
//                Expected Gray codes come from a table built by reflection.
//                Define GRAY_CNT_SATURATE_EN to check the saturating build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_code_counter;
  import gray_pkg::*;

  localparam int WIDTH = 3;
  localparam int NV    = 1 << WIDTH;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             en_in;
  logic             up_in;
  logic             load_in;
  logic [WIDTH-1:0] load_val_in;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             valid_out;
  logic             tc_out;

  gray_code_counter #(
    .WIDTH (WIDTH)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en_in       (en_in),
    .up_in       (up_in),
    .load_in     (load_in),
    .load_val_in (load_val_in),
    .gray_out    (gray_out),
    .bin_out     (bin_out),
    .valid_out   (valid_out),
    .tc_out      (tc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int cyc;
    int bin;
    int gray;
    bit v;
    bit tc;
    bit step;   // count actually moved by one
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cnt;
  int   gtab[NV];
  logic [WIDTH-1:0] prev_gray;
  bit   have_prev;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Reflected Gray table: the codes for k+1 bits are the codes for k bits
  // followed by the same list reversed with bit k set.
  initial begin
    gtab[0] = 0;
    for (int k = 0; k < WIDTH; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | (1 << k);
      end
    end
  end

  // -------------------------------- monitor --------------------------------
  always @(negedge clk_in) begin : mon
    exp_t e;
    logic [GRAY_MAX_WIDTH-1:0] g2b;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      g2b = gray2bin(GRAY_MAX_WIDTH'(gray_out));
      n_chk++;
      if (gray_out !== WIDTH'(e.gray) || bin_out !== WIDTH'(e.bin) ||
          valid_out !== e.v || tc_out !== e.tc || g2b !== GRAY_MAX_WIDTH'(e.bin)) begin
        n_fail++;
        $display("FAIL cycle%0d: got gray=%b bin=%0d valid=%b tc=%b, expected gray=%b bin=%0d valid=%b tc=%b",
                 e.cyc, gray_out, bin_out, valid_out, tc_out,
                 WIDTH'(e.gray), e.bin, e.v, e.tc);
      end
      if (e.step && have_prev) begin
        n_chk++;
        if ($countones(gray_out ^ prev_gray) != 1) begin
          n_fail++;
          $display("FAIL onebit cycle%0d: got %b -> %b, expected exactly one bit change",
                   e.cyc, prev_gray, gray_out);
        end
      end
      prev_gray = gray_out;
      have_prev = 1'b1;
    end
  end

  // --------------------------- driver + model ------------------------------
  task automatic do_cycle(input bit ld, input int val, input bit en, input bit up);
    exp_t e;
    @(posedge clk_in);
    #1;
    load_in     = ld;
    load_val_in = WIDTH'(val);
    en_in       = en;
    up_in       = up;
    e.v    = 1'b0;
    e.tc   = 1'b0;
    e.step = 1'b0;
    if (ld) begin
      cnt = val % NV;
      e.v = 1'b1;
    end else if (en) begin
      e.v = 1'b1;
      if (up && cnt == NV - 1) begin
        e.tc = 1'b1;
`ifndef GRAY_CNT_SATURATE_EN
        cnt    = 0;
        e.step = 1'b1;
`endif
      end else if (!up && cnt == 0) begin
        e.tc = 1'b1;
`ifndef GRAY_CNT_SATURATE_EN
        cnt    = NV - 1;
        e.step = 1'b1;
`endif
      end else begin
        cnt    = up ? cnt + 1 : cnt - 1;
        e.step = 1'b1;
      end
    end
    e.cyc  = cyc + 1;
    e.bin  = cnt;
    e.gray = gtab[cnt];
    sb.push_back(e);
  endtask

  task automatic drain();
    int budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    n_chk++;
    if (gray_out !== '0 || bin_out !== '0 || valid_out !== 1'b0 || tc_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got gray=%b bin=%0d valid=%b tc=%b, expected all zero",
               tag, gray_out, bin_out, valid_out, tc_out);
    end
  endtask

  initial begin
    rst_in = 1'b1; en_in = 1'b0; up_in = 1'b0; load_in = 1'b0; load_val_in = '0;
    cnt = 0; have_prev = 1'b0;
    #12;
    check_reset("reset_state");
    @(posedge clk_in); #1 rst_in = 1'b0;

    // Nine increments through the wrap.
    for (int i = 0; i < 9; i++) do_cycle(0, 0, 1, 1);
    // Load 5, then count down six times.
    do_cycle(1, 5, 0, 0);
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 1, 0);
    // Direction toggling around 3.
    do_cycle(1, 3, 0, 0);
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 1, (i % 2) == 0);
    // Load wins over enable.
    do_cycle(1, 6, 1, 1);
    do_cycle(0, 0, 0, 0);

    // Asynchronous reset away from any clock edge.
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, 1);
    drain();
    #2 rst_in = 1'b1;
    en_in = 1'b1; up_in = 1'b1;
    #1 check_reset("async_reset");
    @(posedge clk_in); #1;
    check_reset("reset_held");
    en_in = 1'b0;
    rst_in = 1'b0;
    cnt = 0; have_prev = 1'b0;
    do_cycle(0, 0, 1, 1);
    do_cycle(0, 0, 0, 0);

    // Top-of-range behaviour: wraps by default, holds when saturating.
    do_cycle(1, 7, 0, 0);
    do_cycle(0, 0, 1, 1);
    do_cycle(0, 0, 1, 1);
    do_cycle(0, 0, 1, 0);
    do_cycle(1, 0, 0, 0);
    do_cycle(0, 0, 1, 0);
    do_cycle(0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      do_cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, NV - 1)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    do_cycle(0, 0, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule : tb_gray_code_counter
`default_nettype wire
